gemm_tile_scheduler: RTL and testbench

- Decomposes one GEMM command (C = A x B, dims M x K x N, SRAM base addresses for A/B/C) into ARRAY_SIZE-square tile operations.
- Issues tile operations to the systolic-array engine in the tensor processing cluster over a valid/ready handshake.
- Tracks completions against an outstanding-tile limit and pulses done once every tile has retired.
- Sits between the TPC instruction decoder (OP_TENSOR) and the MXU tile engine.

---
 rtl/gemm_tile_scheduler_if.sv | 47 ++++
 rtl/gemm_tile_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_gemm_tile_scheduler.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_tile_scheduler_if.sv
// Command and tile-issue bus between the OP_TENSOR decoder, the GEMM tile
// scheduler and the MXU tile engine.
interface gemm_tile_scheduler_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DIM_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DIM_W-1:0]  cmd_m;
    logic [DIM_W-1:0]  cmd_n;
    logic [DIM_W-1:0]  cmd_k;
    logic [ADDR_W-1:0] cmd_a_base;
    logic [ADDR_W-1:0] cmd_b_base;
    logic [ADDR_W-1:0] cmd_c_base;

    logic              tile_valid;
    logic              tile_ready;
    logic [ADDR_W-1:0] tile_a_addr;
    logic [ADDR_W-1:0] tile_b_addr;
    logic [ADDR_W-1:0] tile_c_addr;
    logic [DIM_W-1:0]  tile_rows;
    logic [DIM_W-1:0]  tile_cols;
    logic [DIM_W-1:0]  tile_depth;
    logic              tile_accum;
    logic              tile_last_k;
    logic              tile_done;

    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  cmd_valid, cmd_m, cmd_n, cmd_k, cmd_a_base, cmd_b_base, cmd_c_base,
        input  tile_ready, tile_done,
        output cmd_ready, tile_valid, tile_a_addr, tile_b_addr, tile_c_addr,
        output tile_rows, tile_cols, tile_depth, tile_accum, tile_last_k,
        output busy, done, error
    );

    modport slave (
        output cmd_valid, cmd_m, cmd_n, cmd_k, cmd_a_base, cmd_b_base, cmd_c_base,
        output tile_ready, tile_done,
        input  cmd_ready, tile_valid, tile_a_addr, tile_b_addr, tile_c_addr,
        input  tile_rows, tile_cols, tile_depth, tile_accum, tile_last_k,
        input  busy, done, error
    );
endinterface

// File: rtl/gemm_tile_scheduler.sv
// Splits one GEMM command into ARRAY_SIZE-square tile ops (mt, nt, kt order),
// issues them under an outstanding-tile limit and pulses done when all retire.
module gemm_tile_scheduler #(
    parameter int unsigned ARRAY_SIZE      = 4,
    parameter int unsigned ADDR_W          = 20,
    parameter int unsigned DIM_W           = 16,
    parameter int unsigned TILE_STRIDE     = 16,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic                   clk,
    input logic                   rst,
    gemm_tile_scheduler_if.master bus
);
    localparam int unsigned OW = 4;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
    logic [DIM_W-1:0]  mc_q, mc_d, nc_q, nc_d, kc_q, kc_d;
    logic [DIM_W-1:0]  mt_q, mt_d, nt_q, nt_d, kt_q, kt_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
    logic [OW-1:0]     out_q, out_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              tile_valid_q, tile_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] tile_a_q, tile_b_q, tile_c_q;
    logic [ADDR_W-1:0] tile_a_n, tile_b_n, tile_c_n;
    logic [DIM_W-1:0]  rows_q, cols_q, depth_q, rows_n, cols_n, depth_n;
    logic              accum_q, last_k_q, accum_n, last_k_n;

    logic              hs, retire, last_tile;

    function automatic logic [DIM_W-1:0] tile_count(input logic [DIM_W-1:0] d);
        return d / DIM_W'(ARRAY_SIZE) + DIM_W'((d % DIM_W'(ARRAY_SIZE)) != '0);
    endfunction

    function automatic logic [DIM_W-1:0] extent(input logic [DIM_W-1:0] d,
                                                input logic [DIM_W-1:0] idx);
        logic [DIM_W-1:0] rem;
        rem = d - idx * DIM_W'(ARRAY_SIZE);
        return (rem > DIM_W'(ARRAY_SIZE)) ? DIM_W'(ARRAY_SIZE) : rem;
    endfunction

    // Computed modulo 2^ADDR_W throughout, so truncating the operands is exact.
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [DIM_W-1:0]  outer,
                                                   input logic [DIM_W-1:0]  count,
                                                   input logic [DIM_W-1:0]  inner);
        return base + (ADDR_W'(outer) * ADDR_W'(count) + ADDR_W'(inner))
                      * ADDR_W'(TILE_STRIDE);
    endfunction

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        n_d      = n_q;
        k_d      = k_q;
        mc_d     = mc_q;
        nc_d     = nc_q;
        kc_d     = kc_q;
        mt_d     = mt_q;
        nt_d     = nt_q;
        kt_d     = kt_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        c_base_d = c_base_q;
        done_d   = 1'b0;

        hs        = tile_valid_q & bus.tile_ready;
        retire    = bus.tile_done & (out_q != '0);
        err_d     = bus.tile_done & (out_q == '0);
        out_d     = out_q + OW'(hs) - OW'(retire);
        last_tile = (mt_q == mc_q - DIM_W'(1)) && (nt_q == nc_q - DIM_W'(1))
                    && (kt_q == kc_q - DIM_W'(1));

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    m_d      = bus.cmd_m;
                    n_d      = bus.cmd_n;
                    k_d      = bus.cmd_k;
                    mc_d     = tile_count(bus.cmd_m);
                    nc_d     = tile_count(bus.cmd_n);
                    kc_d     = tile_count(bus.cmd_k);
                    a_base_d = bus.cmd_a_base;
                    b_base_d = bus.cmd_b_base;
                    c_base_d = bus.cmd_c_base;
                    mt_d     = '0;
                    nt_d     = '0;
                    kt_d     = '0;
                    if (bus.cmd_m == '0 || bus.cmd_n == '0 || bus.cmd_k == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (hs) begin
                    if (last_tile) begin
                        state_d = StDrain;
                    end else if (kt_q != kc_q - DIM_W'(1)) begin
                        kt_d = kt_q + DIM_W'(1);
                    end else begin
                        kt_d = '0;
                        if (nt_q != nc_q - DIM_W'(1)) begin
                            nt_d = nt_q + DIM_W'(1);
                        end else begin
                            nt_d = '0;
                            mt_d = mt_q + DIM_W'(1);
                        end
                    end
                end
            end
            StDrain: begin
                if (out_d == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        cmd_ready_d  = (state_d == StIdle);
        busy_d       = (state_d != StIdle);
        tile_valid_d = (state_d == StIssue) && (out_d < OW'(MAX_OUTSTANDING));
    end

    // Tile fields are a pure function of the next indices, so they stay stable under stall.
    assign tile_a_n = tile_addr(a_base_d, mt_d, kc_d, kt_d);
    assign tile_b_n = tile_addr(b_base_d, kt_d, nc_d, nt_d);
    assign tile_c_n = tile_addr(c_base_d, mt_d, nc_d, nt_d);
    assign rows_n   = extent(m_d, mt_d);
    assign cols_n   = extent(n_d, nt_d);
    assign depth_n  = extent(k_d, kt_d);
    assign accum_n  = (kt_d != '0);
    assign last_k_n = (kt_d == kc_d - DIM_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            m_q          <= '0;
            n_q          <= '0;
            k_q          <= '0;
            mc_q         <= '0;
            nc_q         <= '0;
            kc_q         <= '0;
            mt_q         <= '0;
            nt_q         <= '0;
            kt_q         <= '0;
            a_base_q     <= '0;
            b_base_q     <= '0;
            c_base_q     <= '0;
            out_q        <= '0;
            cmd_ready_q  <= 1'b1;
            tile_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            tile_a_q     <= '0;
            tile_b_q     <= '0;
            tile_c_q     <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            depth_q      <= '0;
            accum_q      <= 1'b0;
            last_k_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            m_q          <= m_d;
            n_q          <= n_d;
            k_q          <= k_d;
            mc_q         <= mc_d;
            nc_q         <= nc_d;
            kc_q         <= kc_d;
            mt_q         <= mt_d;
            nt_q         <= nt_d;
            kt_q         <= kt_d;
            a_base_q     <= a_base_d;
            b_base_q     <= b_base_d;
            c_base_q     <= c_base_d;
            out_q        <= out_d;
            cmd_ready_q  <= cmd_ready_d;
            tile_valid_q <= tile_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            if (state_d == StIssue) begin
                tile_a_q <= tile_a_n;
                tile_b_q <= tile_b_n;
                tile_c_q <= tile_c_n;
                rows_q   <= rows_n;
                cols_q   <= cols_n;
                depth_q  <= depth_n;
                accum_q  <= accum_n;
                last_k_q <= last_k_n;
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.tile_valid  = tile_valid_q;
    assign bus.tile_a_addr = tile_a_q;
    assign bus.tile_b_addr = tile_b_q;
    assign bus.tile_c_addr = tile_c_q;
    assign bus.tile_rows   = rows_q;
    assign bus.tile_cols   = cols_q;
    assign bus.tile_depth  = depth_q;
    assign bus.tile_accum  = accum_q;
    assign bus.tile_last_k = last_k_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = err_q;

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Self-checking bench for gemm_tile_scheduler: command table, randomized
// commands against a loop-nest reference model, and hand-written corner cases.
module tb_gemm_tile_scheduler;
    localparam int AS     = 4;
    localparam int ADDR_W = 20;
    localparam int DIM_W  = 16;
    localparam int STRIDE = 16;
    localparam int MAXO   = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] c;
        logic [DIM_W-1:0]  rows;
        logic [DIM_W-1:0]  cols;
        logic [DIM_W-1:0]  depth;
        logic              accum;
        logic              last_k;
    } tile_t;

    typedef struct {
        int m, n, k;
        int a, b, c;
        int ready_pct;
        int lat;
        int stall;
        int exp_tiles;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gemm_tile_scheduler_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

    gemm_tile_scheduler #(
        .ARRAY_SIZE     (AS),
        .ADDR_W         (ADDR_W),
        .DIM_W          (DIM_W),
        .TILE_STRIDE    (STRIDE),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    tile_t exp_q[$];
    tile_t obs_q[$];
    vec_t  vecs[5];
    tile_t gold_single[1];
    tile_t gold_edge[4];

    function automatic void chk(input string name, input bit ok, input string act,
                                input string req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, want %s", name, act, req);
    endfunction

    function automatic string st();
        return $sformatf("valid=%b busy=%b done=%b err=%b ready=%b", bus.tile_valid, bus.busy,
                         bus.done, bus.error, bus.cmd_ready);
    endfunction

    function automatic tile_t cur_tile();
        tile_t t;
        t.a      = bus.tile_a_addr;
        t.b      = bus.tile_b_addr;
        t.c      = bus.tile_c_addr;
        t.rows   = bus.tile_rows;
        t.cols   = bus.tile_cols;
        t.depth  = bus.tile_depth;
        t.accum  = bus.tile_accum;
        t.last_k = bus.tile_last_k;
        return t;
    endfunction

    function automatic tile_t mk(input int a, input int b, input int c, input int r, input int cl,
                                 input int d, input bit acc, input bit lk);
        tile_t t;
        t.a = ADDR_W'(a); t.b = ADDR_W'(b); t.c = ADDR_W'(c);
        t.rows = DIM_W'(r); t.cols = DIM_W'(cl); t.depth = DIM_W'(d);
        t.accum = acc; t.last_k = lk;
        return t;
    endfunction

    function automatic int min_as(input int rem);
        return (rem < AS) ? rem : AS;
    endfunction

    // Reference: plain loop nest straight from the tiling formulas.
    function automatic void build_model(input vec_t v);
        int mtn, ntn, ktn;
        exp_q.delete();
        mtn = (v.m + AS - 1) / AS;
        ntn = (v.n + AS - 1) / AS;
        ktn = (v.k + AS - 1) / AS;
        for (int mt = 0; mt < mtn; mt++)
            for (int nt = 0; nt < ntn; nt++)
                for (int kt = 0; kt < ktn; kt++)
                    exp_q.push_back(mk(v.a + (mt * ktn + kt) * STRIDE,
                                       v.b + (kt * ntn + nt) * STRIDE,
                                       v.c + (mt * ntn + nt) * STRIDE,
                                       min_as(v.m - mt * AS), min_as(v.n - nt * AS),
                                       min_as(v.k - kt * AS), kt != 0, kt == ktn - 1));
    endfunction

    task automatic drive_cmd(input vec_t v);
        bus.cmd_m      = DIM_W'(v.m);
        bus.cmd_n      = DIM_W'(v.n);
        bus.cmd_k      = DIM_W'(v.k);
        bus.cmd_a_base = ADDR_W'(v.a);
        bus.cmd_b_base = ADDR_W'(v.b);
        bus.cmd_c_base = ADDR_W'(v.c);
        bus.cmd_valid  = 1'b1;
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int    issued, outst, total;
        int    due_q[$];
        bit    finished, prev_stall, exp_v, exp_d, hs, td;
        tile_t prev;
        build_model(v);
        obs_q.delete();
        total = exp_q.size();
        issued = 0; outst = 0; finished = 0; prev_stall = 0; prev = '0;
        @(negedge clk);
        chk({tag, " idle_ready"}, bus.cmd_ready === 1'b1 && bus.busy === 1'b0, st(),
            "ready=1 busy=0");
        drive_cmd(v);
        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            exp_d = (issued == total) && (outst == 0);
            exp_v = (issued < total) && (outst < MAXO);
            chk({tag, " status"}, {bus.tile_valid, bus.busy, bus.done, bus.error, bus.cmd_ready}
                === {exp_v, !exp_d, exp_d, 1'b0, exp_d}, st(),
                $sformatf("valid=%b busy=%b done=%b err=0 ready=%b", exp_v, !exp_d, exp_d,
                          exp_d));
            if (prev_stall)
                chk({tag, " stall_hold"}, bus.tile_valid === 1'b1 && cur_tile() === prev,
                    $sformatf("v=%b %h", bus.tile_valid, cur_tile()),
                    $sformatf("v=1 %h", prev));
            if (exp_d) begin
                finished = 1;
                bus.tile_ready = 1'b0;
                bus.tile_done  = 1'b0;
            end else begin
                td = (due_q.size() > 0) && (due_q[0] <= cyc);
                if (td) void'(due_q.pop_front());
                bus.tile_done  = td;
                bus.tile_ready = (cyc <= v.stall) ? 1'b0 : ($urandom_range(99) < v.ready_pct);
                hs = bus.tile_valid && bus.tile_ready;
                if (hs) begin
                    obs_q.push_back(cur_tile());
                    due_q.push_back(cyc + v.lat);
                end
                prev_stall = bus.tile_valid && !bus.tile_ready;
                prev = cur_tile();
                issued += int'(hs);
                outst += int'(hs) - int'(td);
            end
        end
        if (!finished) begin
            chk({tag, " timeout"}, 1'b0, "no completion", "completion within 3000 cycles");
            bus.tile_ready = 1'b0;
            bus.tile_done  = 1'b0;
        end
        @(negedge clk);
        chk({tag, " after_done"}, {bus.tile_valid, bus.busy, bus.done, bus.cmd_ready}
            === 4'b0001, st(), "valid=0 busy=0 done=0 ready=1");
        chk({tag, " tile_count"}, obs_q.size() == total,
            $sformatf("%0d", obs_q.size()), $sformatf("%0d", total));
        if (v.exp_tiles >= 0)
            chk({tag, " table_count"}, obs_q.size() == v.exp_tiles,
                $sformatf("%0d", obs_q.size()), $sformatf("%0d", v.exp_tiles));
        for (int i = 0; i < total && i < obs_q.size(); i++)
            chk($sformatf("%s tile%0d", tag, i), obs_q[i] === exp_q[i],
                $sformatf("%h", obs_q[i]), $sformatf("%h", exp_q[i]));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        bit   quiet;
        vecs[0] = '{4, 4, 4, 'h000, 'h100, 'h200, 100, 3, 0, 1};
        vecs[1] = '{6, 4, 8, 'h100, 'h200, 'h300, 100, 2, 0, 4};
        vecs[2] = '{8, 4, 8, 'h000, 'h040, 'h080, 100, 8, 5, 4};
        vecs[3] = '{8, 8, 8, 'h1000, 'h2000, 'h3000, 100, 1, 0, 8};
        vecs[4] = '{5, 9, 3, 'hFFFF0, 'hFFFE0, 'hFFFF8, 60, 4, 0, 6};
        gold_single[0] = mk('h000, 'h100, 'h200, 4, 4, 4, 0, 1);
        gold_edge[0]   = mk('h100, 'h200, 'h300, 4, 4, 4, 0, 0);
        gold_edge[1]   = mk('h110, 'h210, 'h300, 4, 4, 4, 1, 1);
        gold_edge[2]   = mk('h120, 'h200, 'h310, 2, 4, 4, 0, 0);
        gold_edge[3]   = mk('h130, 'h210, 'h310, 2, 4, 4, 1, 1);

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_m = '0; bus.cmd_n = '0; bus.cmd_k = '0;
        bus.cmd_a_base = '0; bus.cmd_b_base = '0; bus.cmd_c_base = '0;
        bus.tile_ready = 1'b0;
        bus.tile_done  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {bus.tile_valid, bus.busy, bus.done, bus.error, bus.cmd_ready}
            === 5'b00001, st(), "valid=0 busy=0 done=0 err=0 ready=1");
        chk("reset_fields", cur_tile() === '0, $sformatf("%h", cur_tile()), "0");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
            if (i == 0)
                chk("single_gold", obs_q.size() == 1 && obs_q[0] === gold_single[0],
                    (obs_q.size() > 0) ? $sformatf("%h", obs_q[0]) : "none",
                    $sformatf("%h", gold_single[0]));
            if (i == 1)
                for (int j = 0; j < 4; j++)
                    chk($sformatf("edge_gold%0d", j),
                        j < obs_q.size() && obs_q[j] === gold_edge[j],
                        (j < obs_q.size()) ? $sformatf("%h", obs_q[j]) : "none",
                        $sformatf("%h", gold_edge[j]));
        end

        for (int i = 0; i < 20; i++) begin
            rv.m = int'($urandom_range(1, 13));
            rv.n = int'($urandom_range(1, 13));
            rv.k = int'($urandom_range(1, 13));
            rv.a = int'($urandom & 32'hFFFFF);
            rv.b = int'($urandom & 32'hFFFFF);
            rv.c = int'($urandom & 32'hFFFFF);
            rv.ready_pct = int'($urandom_range(30, 100));
            rv.lat = int'($urandom_range(1, 6));
            rv.stall = int'($urandom_range(0, 3));
            rv.exp_tiles = -1;
            run_cmd(rv, $sformatf("rand%0d", i));
        end

        // Zero K: error pulse, nothing issued, command port stays open.
        @(negedge clk);
        rv = '{4, 4, 0, 0, 0, 0, 100, 1, 0, 0};
        drive_cmd(rv);
        bus.tile_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("zero_dim_error", {bus.tile_valid, bus.busy, bus.error, bus.cmd_ready} === 4'b0011,
            st(), "valid=0 busy=0 err=1 ready=1");
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            quiet &= {bus.tile_valid, bus.busy, bus.error, bus.done, bus.cmd_ready} === 5'b00001;
        end
        chk("zero_dim_quiet", quiet, "activity after zero-dim cmd", "idle");
        bus.tile_ready = 1'b0;

        // Spurious tile_done while idle.
        bus.tile_done = 1'b1;
        @(negedge clk);
        bus.tile_done = 1'b0;
        chk("idle_done_error", bus.error === 1'b1 && bus.done === 1'b0, st(), "err=1 done=0");
        @(negedge clk);
        chk("idle_done_clear", {bus.error, bus.done, bus.busy} === 3'b000, st(),
            "err=0 done=0 busy=0");

        // Reset in the middle of an 8x8x8 command.
        rv = '{8, 8, 8, 'h400, 'h500, 'h600, 100, 1, 0, 8};
        drive_cmd(rv);
        bus.tile_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midop_busy", bus.busy === 1'b1, st(), "busy=1");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.tile_ready = 1'b0;
        chk("midop_reset_ctrl", {bus.tile_valid, bus.busy, bus.done, bus.error, bus.cmd_ready}
            === 5'b00001, st(), "valid=0 busy=0 done=0 err=0 ready=1");
        chk("midop_reset_fields", cur_tile() === '0, $sformatf("%h", cur_tile()), "0");
        bus.tile_done = 1'b1;
        @(negedge clk);
        bus.tile_done = 1'b0;
        chk("stale_done_error", bus.error === 1'b1 && bus.done === 1'b0, st(), "err=1 done=0");
        rv = '{4, 4, 4, 'h040, 'h080, 'h0C0, 100, 3, 0, 1};
        run_cmd(rv, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
